ser_tx_shifter: RTL and testbench
=================================

# ser_tx_shifter

Parallel-in/serial-out transmitter. It is the sending end for the team's serial-in shift register, which shifts left and inserts at bit 0. The block accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, with a per-bit valid strobe and a last-bit marker. A receiver that shifts left on every `s_valid` cycle holds the original word once `s_last` has been sampled.

## Interface
- `WIDTH`, default 8: data word width in bits; minimum 2.
- `clk`  in  1  clock; all logic acts on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `d_in`  in  WIDTH  parallel word to transmit.
- `load_valid`  in  1  `d_in` holds a word to send.
- `load_ready`  out  1  block can accept a word this cycle.
- `s_out`  out  1  serial data bit.
- `s_valid`  out  1  `s_out` carries a frame bit this cycle.
- `s_last`  out  1  current bit is the final bit of the frame.
- `busy`  out  1  a frame is in progress.

## Operation
- **States:** IDLE and SHIFT. There is a shift register `sr[WIDTH-1:0]` and a down-counter `cnt` of width $clog2(WIDTH+1).
- **Handshake:** a transfer happens at a rising edge where `load_valid && load_ready`.
- **`load_ready`:** combinational. It equals `reset && (state==IDLE || (state==SHIFT && s_last))`, so it is always 0 while reset is asserted.
- **Accepting a word:**
  - `sr` <= `d_in` and `cnt` <= WIDTH-1.
  - Next state is SHIFT.
  - If the parity feature is compiled in, the parity bit is also latched.
- **In SHIFT:**
  - `s_out` = `sr[WIDTH-1]` and `s_valid` = 1.
  - Each cycle: `sr` <= {`sr[WIDTH-2:0]`, 1'b0} and `cnt` decrements.
- **Frame end:**
  - `s_last` = 1 when `cnt`==0 (and, with parity, when the parity bit is on the line).
  - After the last bit, go to SHIFT again on a transfer in that same cycle; otherwise go to IDLE.
- **Outputs in IDLE:** `s_out`=0, `s_valid`=0, `s_last`=0, `busy`=0.
- **`busy`:** equals (state==SHIFT).
- **Ignored load:** `load_valid` while `load_ready`=0 is ignored. `d_in` is never sampled outside a transfer.
- **Reset mid-frame:** the frame is aborted with no partial completion and no `s_last`. The next frame starts clean from IDLE.

## Timing
- **Reset values:** `s_out`=0, `s_valid`=0, `s_last`=0, `busy`=0, `load_ready`=0 while reset is low. `load_ready` is 1 in the first cycle after reset goes high.
- **Latency:** the first bit (MSB) appears in the cycle after the transfer edge.
- **Frame length:** WIDTH cycles, or WIDTH+1 with parity.
- **Back-to-back:** a transfer during the last-bit cycle gives a gap-free stream; the new word's MSB follows the old frame's last bit directly.
- **Reset precedence:** reset low at an edge overrides a simultaneous transfer, and the word is dropped.
- **Registered outputs:** `s_out`, `s_valid`, `s_last` and `busy` come from registers; `load_ready` is the only combinational output.

## Configuration
- **Macro `SER_TX_PARITY_EN`:**
  - **Defined:** a transfer latches `par` = ^`d_in` (even parity). After the data LSB, one extra cycle drives `s_out`=`par` with `s_valid`=1 and `s_last`=1. The data LSB then has `s_last`=0. `cnt` starts at WIDTH.
  - **Undefined:** there is no parity register, and frames are exactly WIDTH bits.

## Structure
- **Shared package:** the state enum (IDLE, SHIFT), the default width constant `SER_WIDTH_DEF`=8, and the frame-length function `ser_frame_len(width)`. The function returns width+1 when `SER_TX_PARITY_EN` is defined.
- **Sub-modules:** none. Counter, shift register and parity XOR-reduce are inline; the block is a single module.

## Test plan
1. **Reset:** hold reset low for 3 cycles with `load_valid`=1 and `d_in`=8'hFF → all outputs 0 and `load_ready`=0 throughout. `load_ready`=1 on the first cycle after release, and no frame was started.
2. **Single frame:** load 8'hA5 → `s_out` = 1,0,1,0,0,1,0,1 on cycles 1–8 after the transfer, `s_valid`=1 on all 8 and `s_last` only on cycle 8. A loopback receiver in shift mode then holds 8'hA5.
3. **Back-to-back:** hold `load_valid` with 8'hFF, then switch `d_in` to 8'h00 → the second transfer lands on the `s_last` cycle and 16 contiguous `s_valid` bits appear (eight 1s then eight 0s). `busy` never drops.
4. **Blocked load:** assert `load_valid` with 8'h3C during bit 3 of a frame carrying 8'h81 → `load_ready`=0 and the 8'h81 bits are undisturbed. 8'h3C is accepted at the 8'h81 `s_last` cycle.
5. **Reset mid-frame:** pull reset low during bit 4 of 8'hF0 → `s_valid`=0 on the next cycle and no `s_last` appears. After release, 8'h81 transmits as 1,0,0,0,0,0,0,1.
6. **Parity (`SER_TX_PARITY_EN` defined):** load 8'h07 → 9 valid bits: 0,0,0,0,0,1,1,1 then parity 1, with `s_last` only on the 9th. For 8'h03 the parity bit is 0.

Source files
------------

// File: rtl/ser_tx_shifter_pkg.sv
// Shared types and constants for the serial transmit shifter.
// Honours SER_TX_PARITY_EN: when defined, frames carry one trailing even-parity bit.
package ser_tx_shifter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SER_WIDTH_DEF = 8;

  // Number of serial bit cycles a single word occupies on the line.
  function automatic int ser_frame_len(input int width);
`ifdef SER_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/ser_tx_shifter.sv
// Parallel-in/serial-out transmitter: MSB-first bit stream with valid and last strobes.
// Optional trailing even-parity bit when SER_TX_PARITY_EN is defined.
module ser_tx_shifter
  import ser_tx_shifter_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_START = CW'(ser_frame_len(WIDTH) - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             take;
  logic             fill;

`ifdef SER_TX_PARITY_EN
  logic par;
  // Parity enters at bit 0 on the first shift and reaches the MSB right after the data LSB.
  assign fill = (cnt == CNT_START) ? par : 1'b0;
`else
  assign fill = 1'b0;
`endif

  // The last-bit cycle doubles as an accept slot so frames can run back-to-back.
  assign load_ready = reset && (state == IDLE || (state == SHIFT && s_last));
  assign take       = load_valid && load_ready;

  // The line bit is the register MSB itself; sr is cleared outside a frame so the line idles low.
  assign s_out = sr[WIDTH-1];

  // NOTE: reset is sampled only on the clock edge, so it sits inside the clocked
  // branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      busy    <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (take) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others, whatever the statement order.
      state   <= SHIFT;
      sr      <= d_in;
      cnt     <= CNT_START;
      s_valid <= 1'b1;
      s_last  <= 1'b0;
      busy    <= 1'b1;
`ifdef SER_TX_PARITY_EN
      par     <= ^d_in;
`endif
    end else if (state == SHIFT && !s_last) begin
      sr      <= {sr[WIDTH-2:0], fill};
      cnt     <= cnt - CW'(1);
      s_valid <= 1'b1;
      s_last  <= (cnt == CW'(1));
      busy    <= 1'b1;
    end else begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      busy    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser_tx_shifter.sv
// Self-checking bench for ser_tx_shifter: queue-of-bits reference model plus a loopback receiver.
// Covers both builds; parity vectors run only when SER_TX_PARITY_EN is defined.
module tb_ser_tx_shifter;
  import ser_tx_shifter_pkg::*;

  localparam int W  = 8;
  localparam int FL = ser_frame_len(W);
`ifdef SER_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam logic [63:0] E_A5   = 64'h14A;    // {A5, p=0}
  localparam logic [63:0] E_B2B  = 64'h3FC00;  // {FF, p=0, 00, p=0}
  localparam logic [63:0] E_BLK  = 64'h20478;  // {81, p=0, 3C, p=0}
  localparam logic [63:0] E_81   = 64'h102;    // {81, p=0}
`else
  localparam bit PAR_EN = 1'b0;
  localparam logic [63:0] E_A5   = 64'hA5;
  localparam logic [63:0] E_B2B  = 64'hFF00;
  localparam logic [63:0] E_BLK  = 64'h813C;
  localparam logic [63:0] E_81   = 64'h81;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] d_in;
  logic         load_valid;
  logic         load_ready;
  logic         s_out;
  logic         s_valid;
  logic         s_last;
  logic         busy;

  always #5 clk = ~clk;

  ser_tx_shifter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .s_out      (s_out),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .busy       (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the line is a queue of pending bits; a frame is the word MSB-first plus optional parity.
  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t q[$];
  logic     cur_valid = 1'b0;
  logic     cur_bit   = 1'b0;
  logic     cur_last  = 1'b0;

  logic [63:0] rx       = '0;
  int          rx_n     = 0;
  int          last_n   = 0;
  int          busy_low = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_bit_t e;
    logic     ready;
    if (!reset) begin
      q.delete();
      cur_valid = 1'b0;
      cur_bit   = 1'b0;
      cur_last  = 1'b0;
    end else begin
      ready = !cur_valid || cur_last;
      if (load_valid && ready) begin
        for (int i = W - 1; i >= 0; i--)
          q.push_back('{b: d_in[i], last: (i == 0) && !PAR_EN});
        if (PAR_EN)
          q.push_back('{b: ^d_in, last: 1'b1});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_valid = 1'b1;
        cur_bit   = e.b;
        cur_last  = e.last;
      end else begin
        cur_valid = 1'b0;
        cur_bit   = 1'b0;
        cur_last  = 1'b0;
      end
    end
  endtask

  task automatic compare();
    check("load_ready", 64'(load_ready), 64'(reset && (!cur_valid || cur_last)));
    check("s_out",      64'(s_out),      64'(cur_bit));
    check("s_valid",    64'(s_valid),    64'(cur_valid));
    check("s_last",     64'(s_last),     64'(cur_last));
    check("busy",       64'(busy),       64'(cur_valid));
  endtask

  task automatic capture();
    if (s_valid) begin
      rx = {rx[62:0], s_out};
      rx_n++;
    end
    if (s_last) last_n++;
    if (!busy) busy_low++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    capture();
  endtask

  function automatic logic [63:0] tail(input int n);
    return rx & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic send(input logic [W-1:0] w);
    d_in       = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    int l;
    int b;

    // Reset held with a word offered: nothing may be accepted.
    reset      = 1'b0;
    load_valid = 1'b1;
    d_in       = 8'hFF;
    repeat (3) tick();
    check("t1_ready_in_reset", 64'(load_ready), 64'd0);
    check("t1_valid_in_reset", 64'(s_valid), 64'd0);
    reset      = 1'b1;
    load_valid = 1'b0;
    #1;
    check("t1_ready_after_release", 64'(load_ready), 64'd1);
    tick();
    check("t1_no_frame_started", 64'(s_valid), 64'd0);

    // Single frame with loopback receiver.
    m = rx_n;
    l = last_n;
    send(8'hA5);
    repeat (FL - 1) tick();
    check("t2_last_on_final", 64'(s_last), 64'd1);
    tick();
    check("t2_bit_count", 64'(rx_n - m), 64'(FL));
    check("t2_rx_word", tail(FL), E_A5);
    check("t2_last_count", 64'(last_n - l), 64'd1);

    // Back-to-back: second word accepted on the last-bit cycle.
    m = rx_n;
    b = busy_low;
    d_in       = 8'hFF;
    load_valid = 1'b1;
    tick();
    d_in = 8'h00;
    repeat (FL - 1) tick();
    check("t3_ready_on_last", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    repeat (FL - 1) tick();
    check("t3_busy_never_dropped", 64'(busy_low - b), 64'd0);
    tick();
    check("t3_bit_count", 64'(rx_n - m), 64'(2 * FL));
    check("t3_stream", tail(2 * FL), E_B2B);

    // Blocked load mid-frame, accepted at the last bit.
    m = rx_n;
    send(8'h81);
    tick();
    tick();
    d_in       = 8'h3C;
    load_valid = 1'b1;
    #1;
    check("t4_blocked_ready", 64'(load_ready), 64'd0);
    repeat (FL - 3) tick();
    check("t4_ready_at_last", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    repeat (FL - 1) tick();
    tick();
    check("t4_bit_count", 64'(rx_n - m), 64'(2 * FL));
    check("t4_stream", tail(2 * FL), E_BLK);

    // Reset mid-frame aborts without a last strobe.
    m = rx_n;
    l = last_n;
    send(8'hF0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("t5_valid_after_reset", 64'(s_valid), 64'd0);
    reset = 1'b1;
    tick();
    check("t5_no_last", 64'(last_n - l), 64'd0);
    check("t5_partial_bits", 64'(rx_n - m), 64'd4);
    m = rx_n;
    send(8'h81);
    repeat (FL - 1) tick();
    tick();
    check("t5_bit_count", 64'(rx_n - m), 64'(FL));
    check("t5_rx_word", tail(FL), E_81);

`ifdef SER_TX_PARITY_EN
    // Odd and even population words.
    m = rx_n;
    send(8'h07);
    repeat (FL - 1) tick();
    check("t6_last_on_parity", 64'(s_last), 64'd1);
    tick();
    check("t6_par07_count", 64'(rx_n - m), 64'd9);
    check("t6_par07_word", tail(9), 64'h00F);
    m = rx_n;
    send(8'h03);
    repeat (FL - 1) tick();
    tick();
    check("t6_par03_word", tail(9), 64'h006);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
